// File: rtl/avm_arb_pkg.sv
// Shared types for the two-requester Avalon-MM arbiter.
package avm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic gnt_idx_t;

endpackage

// File: rtl/avm_arbiter.sv
// Two-requester Avalon-MM arbiter with per-transfer round robin onto one slave.
// Optional grant locking is enabled by defining AVM_ARB_LOCK_EN.
module avm_arbiter
    import avm_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    output logic [DATA_W-1:0] avs_s0_readdata,
    output logic              avs_s0_waitrequest,
    input  logic [ADDR_W-1:0] avs_s1_address,
    input  logic              avs_s1_read,
    input  logic              avs_s1_write,
    input  logic [DATA_W-1:0] avs_s1_writedata,
    output logic [DATA_W-1:0] avs_s1_readdata,
    output logic              avs_s1_waitrequest,
`ifdef AVM_ARB_LOCK_EN
    input  logic              avs_s0_lock,
    input  logic              avs_s1_lock,
`endif
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read,
    output logic              avm_m0_write,
    output logic [DATA_W-1:0] avm_m0_writedata,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_waitrequest
);

    if (MAX_LOCK < 1) begin : g_bad_max_lock
        $error("MAX_LOCK must be at least 1");
    end

    arb_state_t r_state;
    gnt_idx_t   r_last;
    gnt_idx_t   w_gnt;
    gnt_idx_t   w_winner;
    logic       w_req0;
    logic       w_req1;
    logic       w_req_k;
    logic       w_req_o;
    logic       w_done;
    logic       w_hold;
    logic       w_switch;

    assign w_req0   = avs_s0_read | avs_s0_write;
    assign w_req1   = avs_s1_read | avs_s1_write;
    assign w_gnt    = (r_state == GRANT1);
    assign w_req_k  = w_gnt ? w_req1 : w_req0;
    assign w_req_o  = w_gnt ? w_req0 : w_req1;
    assign w_done   = (r_state != IDLE) && w_req_k && !avm_m0_waitrequest;
    // Contention out of IDLE goes to whichever requester was not granted last.
    assign w_winner = (w_req0 && w_req1) ? ~r_last : w_req1;
    assign w_switch = (r_state != IDLE) && !w_hold && (w_done || !w_req_k) && w_req_o;

`ifdef AVM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [CNT_W-1:0] r_lock_cnt;
    logic             w_lock_k;

    assign w_lock_k = w_gnt ? avs_s1_lock : avs_s0_lock;
    assign w_hold   = w_done && w_lock_k && (r_lock_cnt < CNT_W'(MAX_LOCK - 1));

    // The counter counts locked completions already granted back to the owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_cnt <= '0;
        end else if (w_switch) begin
            r_lock_cnt <= '0;
        end else if (w_hold) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end else if (w_done) begin
            r_lock_cnt <= '0;
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_state <= w_winner ? GRANT1 : GRANT0;
                        r_last  <= w_winner;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_switch) begin
                        r_state <= w_gnt ? GRANT0 : GRANT1;
                        r_last  <= ~w_gnt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        avm_m0_address     = '0;
        avm_m0_read        = 1'b0;
        avm_m0_write       = 1'b0;
        avm_m0_writedata   = '0;
        avs_s0_readdata    = '0;
        avs_s1_readdata    = '0;
        avs_s0_waitrequest = 1'b1;
        avs_s1_waitrequest = 1'b1;
        case (r_state)
            GRANT0: begin
                avm_m0_address     = avs_s0_address;
                avm_m0_write       = avs_s0_write;
                avm_m0_read        = avs_s0_read & ~avs_s0_write;
                avm_m0_writedata   = avs_s0_writedata;
                avs_s0_readdata    = avm_m0_readdata;
                avs_s0_waitrequest = avm_m0_waitrequest;
            end
            GRANT1: begin
                avm_m0_address     = avs_s1_address;
                avm_m0_write       = avs_s1_write;
                avm_m0_read        = avs_s1_read & ~avs_s1_write;
                avm_m0_writedata   = avs_s1_writedata;
                avs_s1_readdata    = avm_m0_readdata;
                avs_s1_waitrequest = avm_m0_waitrequest;
            end
            default: ;
        endcase
    end

endmodule
